// File: rtl/pulse_gen_if.sv
// pulse_gen request/waveform bundle.
// PULSE_GEN_REPEAT_EN adds the count field.
interface pulse_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
`ifdef PULSE_GEN_REPEAT_EN
  logic [CNT_W-1:0] count;
`endif
  logic             sig;
  logic             busy;
  logic             done;

`ifdef PULSE_GEN_REPEAT_EN
  modport master (
    output start, high_len, low_len, count,
    input  sig, busy, done
  );
  modport slave (
    input  start, high_len, low_len, count,
    output sig, busy, done
  );
`else
  modport master (
    output start, high_len, low_len,
    input  sig, busy, done
  );
  modport slave (
    input  start, high_len, low_len,
    output sig, busy, done
  );
`endif
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: high/low waveform source, registered outputs.
// PULSE_GEN_REPEAT_EN enables the repeat counter (N pairs).
module pulse_gen #(
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pulse_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] hlen_q, hlen_d;
  logic [CNT_W-1:0] llen_q, llen_d;
`ifdef PULSE_GEN_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
`endif
  logic             sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Phase counter preload; a zero length behaves like one cycle.
  function automatic logic [CNT_W-1:0] ld(
    input logic [CNT_W-1:0] len
  );
    if (len == '0) return '0;
    return len - CNT_W'(1);
  endfunction

  // Next state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hlen_d  = hlen_q;
    llen_d  = llen_q;
`ifdef PULSE_GEN_REPEAT_EN
    rep_d   = rep_q;
`endif
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          hlen_d  = bus.high_len;
          llen_d  = bus.low_len;
`ifdef PULSE_GEN_REPEAT_EN
          rep_d   = bus.count;
`endif
          phase_d = ld(bus.high_len);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          phase_d = ld(llen_q);
          state_d = LOW;
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (phase_q == '0) begin
`ifdef PULSE_GEN_REPEAT_EN
          if (rep_q > CNT_W'(1)) begin
            rep_d   = rep_q - CNT_W'(1);
            phase_d = ld(hlen_q);
            state_d = HIGH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sig_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      hlen_q  <= '0;
      llen_q  <= '0;
`ifdef PULSE_GEN_REPEAT_EN
      rep_q   <= '0;
`endif
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hlen_q  <= hlen_d;
      llen_q  <= llen_d;
`ifdef PULSE_GEN_REPEAT_EN
      rep_q   <= rep_d;
`endif
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sig  = sig_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
